uart_rx_fifo: RTL and testbench

//  Receive-side byte buffer directly downstream of the UART receiver.

---
 rtl/uart_pkg.sv | 25 ++
 rtl/uart_fifo_ram.sv | 36 +++
 rtl/uart_rx_fifo.sv | 112 +++++++++++
 tb/tb_uart_rx_fifo.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// ============================================================================
// Module  : uart_pkg
// Brief   : Shared widths and constants for the UART receive FIFO slice.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_pkg;

    localparam int c_data_width = 8;
    localparam int c_addr_width = 4;

    // Pointers carry one extra wrap bit above the RAM address.
    function automatic int ptr_width(input int addr_width);
        return addr_width + 1;
    endfunction

    typedef logic [c_addr_width:0] ptr_t;

    localparam int                     c_ovr_cnt_w   = 8;
    localparam logic [c_ovr_cnt_w-1:0] c_ovr_cnt_max = 8'hFF;

endpackage

`default_nettype wire

// File: rtl/uart_fifo_ram.sv
// ============================================================================
// Module  : uart_fifo_ram
// Brief   : Simple dual-port RAM, one synchronous write, one async read port.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_fifo_ram
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = c_data_width,
    parameter int ADDR_WIDTH = c_addr_width
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    localparam int c_depth = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] r_mem [c_depth];

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    assign rdata = r_mem[raddr];

endmodule

`default_nettype wire

// File: rtl/uart_rx_fifo.sv
// ============================================================================
// Module  : uart_rx_fifo
// Brief   : Receive byte FIFO with first-word fall-through stream output and
//           sticky overrun flag. Define UART_RX_FIFO_OVR_CNT_EN to add a
//           saturating dropped-byte counter on port ovr_count.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = c_data_width,
    parameter int ADDR_WIDTH = c_addr_width
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_stb,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [ADDR_WIDTH:0]   level,
    output logic                  full,
    output logic                  overrun,
    input  logic                  ovr_clr
`ifdef UART_RX_FIFO_OVR_CNT_EN
    ,
    output logic [c_ovr_cnt_w-1:0] ovr_count
`endif
);

    localparam int c_ptr_w = ptr_width(ADDR_WIDTH);

    logic [c_ptr_w-1:0]    r_wr_ptr;
    logic [c_ptr_w-1:0]    r_rd_ptr;
    logic [c_ptr_w-1:0]    w_wr_next;
    logic [c_ptr_w-1:0]    w_rd_next;
    logic [ADDR_WIDTH:0]   r_level;
    logic                  r_full;
    logic                  r_m_valid;
    logic                  r_overrun;
    logic                  w_pop;
    logic                  w_push;
    logic                  w_drop;
    logic [DATA_WIDTH-1:0] w_rdata;

    // A pop in the same cycle frees a slot, so a full FIFO can still accept.
    assign w_pop  = r_m_valid & m_ready;
    assign w_push = wr_stb & (~r_full | w_pop);
    assign w_drop = wr_stb & r_full & ~w_pop;

    assign w_wr_next = w_push ? r_wr_ptr + 1'b1 : r_wr_ptr;
    assign w_rd_next = w_pop  ? r_rd_ptr + 1'b1 : r_rd_ptr;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_level   <= '0;
            r_full    <= 1'b0;
            r_m_valid <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_wr_ptr  <= w_wr_next;
            r_rd_ptr  <= w_rd_next;
            r_level   <= w_wr_next - w_rd_next;
            r_full    <= (w_wr_next[ADDR_WIDTH-1:0] == w_rd_next[ADDR_WIDTH-1:0]) &&
                         (w_wr_next[ADDR_WIDTH] != w_rd_next[ADDR_WIDTH]);
            r_m_valid <= (w_wr_next != w_rd_next);
            r_overrun <= w_drop | (r_overrun & ~ovr_clr);
        end
    end

    uart_fifo_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clk   (clk),
        .we    (w_push),
        .waddr (r_wr_ptr[ADDR_WIDTH-1:0]),
        .wdata (wr_data),
        .raddr (r_rd_ptr[ADDR_WIDTH-1:0]),
        .rdata (w_rdata)
    );

    assign m_data  = r_m_valid ? w_rdata : '0;
    assign m_valid = r_m_valid;
    assign level   = r_level;
    assign full    = r_full;
    assign overrun = r_overrun;

`ifdef UART_RX_FIFO_OVR_CNT_EN
    logic [c_ovr_cnt_w-1:0] r_ovr_count;

    // A clear that coincides with a drop leaves that drop counted.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ovr_count <= '0;
        end else if (ovr_clr) begin
            r_ovr_count <= c_ovr_cnt_w'(w_drop);
        end else if (w_drop && (r_ovr_count != c_ovr_cnt_max)) begin
            r_ovr_count <= r_ovr_count + 1'b1;
        end
    end

    assign ovr_count = r_ovr_count;
`endif

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
// ============================================================================
// Module  : tb_uart_rx_fifo
// Brief   : Self-checking bench for uart_rx_fifo against a queue-based model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_rx_fifo;

    localparam int c_depth = 16;

    logic       clk;
    logic       reset;
    logic       wr_stb;
    logic [7:0] wr_data;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_ready;
    logic [4:0] level;
    logic       full;
    logic       overrun;
    logic       ovr_clr;
`ifdef UART_RX_FIFO_OVR_CNT_EN
    logic [7:0] ovr_count;
`endif

    uart_rx_fifo dut (
        .clk     (clk),
        .reset   (reset),
        .wr_stb  (wr_stb),
        .wr_data (wr_data),
        .m_data  (m_data),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .level   (level),
        .full    (full),
        .overrun (overrun),
        .ovr_clr (ovr_clr)
`ifdef UART_RX_FIFO_OVR_CNT_EN
        ,
        .ovr_count (ovr_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: contents as a plain queue plus flag and drop count.
    logic [7:0] mdl_q [$];
    logic       mdl_ovr;
    int         mdl_cnt;
    logic [7:0] rx_q [$];
    logic       prev_stall;
    logic [7:0] prev_data;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic do_reset();
        reset   = 1'b1;
        wr_stb  = 1'b0;
        wr_data = 8'h00;
        m_ready = 1'b0;
        ovr_clr = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        mdl_q.delete();
        mdl_ovr    = 1'b0;
        mdl_cnt    = 0;
        prev_stall = 1'b0;
    endtask

    // One clock: drive, compare outputs against the model, then advance the model.
    task automatic cycle(input logic stb, input logic [7:0] d, input logic rdy, input logic clr);
        logic pop;
        logic drop;
        wr_stb  = stb;
        wr_data = d;
        m_ready = rdy;
        ovr_clr = clr;
        @(negedge clk);
        check("m_valid", 32'(m_valid), 32'(mdl_q.size() != 0));
        check("level", 32'(level), 32'(mdl_q.size()));
        check("full", 32'(full), 32'(mdl_q.size() == c_depth));
        check("overrun", 32'(overrun), 32'(mdl_ovr));
        check("m_data", 32'(m_data), (mdl_q.size() != 0) ? 32'(mdl_q[0]) : 32'd0);
`ifdef UART_RX_FIFO_OVR_CNT_EN
        check("ovr_count", 32'(ovr_count), 32'(mdl_cnt));
`endif
        if (prev_stall) check("stall_hold", 32'(m_data), 32'(prev_data));
        prev_stall = m_valid && !rdy;
        prev_data  = m_data;
        if (m_valid && rdy) rx_q.push_back(m_data);

        pop  = (mdl_q.size() != 0) && rdy;
        drop = stb && (mdl_q.size() == c_depth) && !pop;
        if (pop) void'(mdl_q.pop_front());
        if (stb && !drop) mdl_q.push_back(d);
        mdl_ovr = drop ? 1'b1 : (clr ? 1'b0 : mdl_ovr);
        if (clr) mdl_cnt = drop ? 1 : 0;
        else if (drop && mdl_cnt < 255) mdl_cnt++;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] tx_q [$];
        logic [7:0] b;
        int sent;
        int cyc;

        do_reset();
        cycle(1'b0, 8'h00, 1'b0, 1'b0);

        // Single byte in, then out.
        cycle(1'b1, 8'hA5, 1'b0, 1'b0);
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        cycle(1'b0, 8'h00, 1'b0, 1'b0);

        // Fill, overrun with 0x55, drain in order.
        for (int i = 0; i < c_depth; i++) cycle(1'b1, 8'(i), 1'b0, 1'b0);
        cycle(1'b1, 8'h55, 1'b0, 1'b0);
        rx_q.delete();
        for (int i = 0; i < c_depth; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);
        cycle(1'b0, 8'h00, 1'b0, 1'b0);
        check("drain_count", 32'(rx_q.size()), 32'(c_depth));
        for (int i = 0; i < rx_q.size(); i++) check("drain_order", 32'(rx_q[i]), 32'(i));

        // Push while full with a same-cycle pop.
        cycle(1'b0, 8'h00, 1'b0, 1'b1);
        for (int i = 0; i < c_depth; i++) cycle(1'b1, 8'(8'h80 + i), 1'b0, 1'b0);
        cycle(1'b1, 8'h77, 1'b1, 1'b0);
        rx_q.delete();
        for (int i = 0; i < c_depth; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);
        cycle(1'b0, 8'h00, 1'b0, 1'b0);
        check("last_is_77", (rx_q.size() != 0) ? 32'(rx_q[rx_q.size()-1]) : 32'hFFFF, 32'h77);

        // Randomized stream across pointer wrap.
        rx_q.delete();
        sent = 0;
        cyc  = 0;
        while ((sent < 40 || mdl_q.size() != 0) && cyc < 2000) begin
            logic stb;
            stb = (cyc % 3 == 0) && (sent < 40) && (mdl_q.size() < c_depth);
            b   = 8'($urandom);
            cycle(stb, b, 1'($urandom_range(0, 1)), 1'b0);
            if (stb) begin
                tx_q.push_back(b);
                sent++;
            end
            cyc++;
        end
        check("stream_timeout", 32'(cyc < 2000), 32'd1);
        check("stream_count", 32'(rx_q.size()), 32'd40);
        for (int i = 0; i < rx_q.size() && i < tx_q.size(); i++)
            check("stream_order", 32'(rx_q[i]), 32'(tx_q[i]));

        // Overrun clear, then clear coinciding with a drop.
        for (int i = 0; i < c_depth; i++) cycle(1'b1, 8'($urandom), 1'b0, 1'b0);
        cycle(1'b1, 8'hEE, 1'b0, 1'b0);
        cycle(1'b0, 8'h00, 1'b0, 1'b1);
        cycle(1'b1, 8'hEF, 1'b0, 1'b1);
        cycle(1'b0, 8'h00, 1'b0, 1'b0);
        for (int i = 0; i < 300; i++) cycle(1'b1, 8'($urandom), 1'b0, 1'b0);
        cycle(1'b0, 8'h00, 1'b0, 1'b0);

        // Reset with contents, then fresh byte comes out first.
        do_reset();
        for (int i = 0; i < 5; i++) cycle(1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
        do_reset();
        cycle(1'b1, 8'h3C, 1'b0, 1'b0);
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        cycle(1'b0, 8'h00, 1'b0, 1'b0);

        // Random mixed traffic including clears.
        for (int i = 0; i < 400; i++)
            cycle(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 3) == 0),
                  1'($urandom_range(0, 15) == 0));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
